dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-port load/store requests.
- Accepts one request at a time, inserts a programmable number of wait states, then returns read data or commits write data with a one-cycle ready pulse.
- Sits between the processor bus (addr/wdata/we) and a word-organised single-port storage array. Used to exercise stall-capable multicycle/pipelined cores.

Parameters:
- ADDR_W, 6, word-address bits; the array holds 2**ADDR_W 32-bit words.
- LATENCY, 2, wait cycles between acceptance and response; 0 is legal.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- req  in  1  request strobe, sampled only in IDLE
- we  in  1  1 = store, 0 = load; captured with req
- addr  in  32  byte address; captured with req
- wdata  in  32  store data; captured with req
- busy  out  1  high in WAIT and RESP; request not acceptable
- ready  out  1  one-cycle response pulse
- rdata  out  32  load data, valid only while ready=1
- err  out  1  misaligned-access flag, valid only while ready=1

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, ready=0, err=0, rdata=0, latency counter=0, captured registers=0. Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE: on a rising edge with req=1, capture we/addr/wdata and load the counter with LATENCY.
  - If LATENCY=0, go to RESP. Otherwise go to WAIT.
  - With req=0, stay in IDLE.
- WAIT: decrement the counter each cycle. When counter==1, the next state is RESP. Total cycles in WAIT = LATENCY.
- RESP: exactly one cycle, ready=1.
  - Load: rdata = mem[addr_q[ADDR_W+1:2]].
  - Store: the array is written at the rising edge that ends RESP, and rdata=0.
  - The next state is always IDLE. A req seen during RESP is ignored; the requester must hold or re-assert it.
- Latency: acceptance edge to ready high = LATENCY+1 cycles. Minimum request-to-request spacing = LATENCY+2 cycles.
- Inputs after acceptance: req, addr, wdata and we may change freely after the acceptance edge. Only the captured copies are used.
- Misaligned access (addr_q[1:0]!=0): err=1 with ready; no array write; rdata=0. Timing is identical to an aligned access.
- Address aliasing: address bits above ADDR_W+1 are ignored, so accesses alias modulo 2**ADDR_W words. This is not an error.
- Output timing: ready, rdata and err are registered, with no combinational path from inputs. busy = (state != IDLE).
- Reset mid-operation (WAIT or RESP): abort and return to IDLE. A pending store is not committed; an array write never occurs on a reset edge.
- Counter width: $clog2(LATENCY+1), minimum 1 bit.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t
  - localparam WORD_W=32
  - a function is_misaligned(addr)
- One sub-module, ram_sp, is natural: a synchronous-write, asynchronous-read single-port array, parameterised on ADDR_W.
  - dmem_responder instantiates it and drives its write enable only in RESP when we_q=1, err=0 and reset=0.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010 (LATENCY=2), then load 0x0000_0010 -> ready rises 3 cycles after each acceptance; the load returns rdata=0xDEADBEEF, err=0; the store returns rdata=0.
- Load 0x0000_0013 after storing 0x12345678 to 0x0000_0010 -> err=1, rdata=0, ready at the same cycle as an aligned load; a later aligned load of 0x10 still returns 0x12345678.
- Store 0xA5A5A5A5 to 0x0000_0104 with ADDR_W=6 -> a load from 0x0000_0004 returns 0xA5A5A5A5 (aliasing).
- Hold req=1 continuously with alternating addresses -> accepted only in IDLE, every LATENCY+2 cycles; busy=1 for exactly LATENCY+1 cycles per request; the address changing after acceptance does not affect the result.
- Store 0x11111111 to 0x20, then assert reset during WAIT of a store of 0x22222222 to 0x20 -> busy/ready/err drop immediately; a subsequent load of 0x20 returns 0x11111111.
- LATENCY=0 build: a single load -> ready exactly 1 cycle after acceptance; a back-to-back request is accepted on the edge after RESP.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_W = 32;

    // Only the two byte-offset bits matter for word alignment.
    function automatic logic is_misaligned(input logic [1:0] addr);
        return (addr != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Processor data-port bus between a requester (master) and the responder (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              busy;
    logic              ready;
    logic [WORD_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  busy, ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, ready, rdata, err
    );

endinterface

// File: rtl/ram_sp.sv
// Single-port word array: synchronous write, asynchronous read, contents never reset.
module ram_sp
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [2**ADDR_W];

    // Word write on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, then a
// one-cycle registered ready pulse carrying load data or a misalignment flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

    dmem_state_t       state_r;
    dmem_state_t       next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              we_r;
    logic [WORD_W-1:0] addr_r;
    logic [WORD_W-1:0] wdata_r;
    logic              ready_r;
    logic              err_r;
    logic [WORD_W-1:0] rdata_r;

    logic              accept_s;
    logic              src_we_s;
    logic [WORD_W-1:0] src_addr_s;
    logic              resp_err_s;
    logic [WORD_W-1:0] resp_rdata_s;
    logic              ram_we_s;
    logic [WORD_W-1:0] ram_rdata_s;
    logic              addr_unused_s;

    assign accept_s = (state_r == IDLE) && bus.req;

    // With LATENCY=0 the response is formed on the acceptance edge, so the
    // live bus fields stand in for the not-yet-captured copies while idle.
    always_comb begin
        src_we_s   = we_r;
        src_addr_s = addr_r;
        if (state_r == IDLE) begin
            src_we_s   = bus.we;
            src_addr_s = bus.addr;
        end else begin
            src_we_s   = we_r;
            src_addr_s = addr_r;
        end
    end

    // Response payload that will be registered when entering RESP.
    always_comb begin
        resp_err_s   = is_misaligned(src_addr_s[1:0]);
        resp_rdata_s = {WORD_W{1'b0}};
        if (!src_we_s && !resp_err_s) begin
            resp_rdata_s = ram_rdata_s;
        end else begin
            resp_rdata_s = {WORD_W{1'b0}};
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    next_s = (LATENCY == 0) ? RESP : WAIT;
                end else begin
                    next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    next_s = RESP;
                end else begin
                    next_s = WAIT;
                end
            end
            RESP:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Wait-state counter and request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            addr_r  <= {WORD_W{1'b0}};
            wdata_r <= {WORD_W{1'b0}};
        end else if (accept_s) begin
            cnt_r   <= LAT_INIT;
            we_r    <= bus.we;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
        end else if (state_r == WAIT) begin
            cnt_r   <= cnt_r - CNT_W'(1);
        end
    end

    // Registered response outputs, zero outside the RESP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= {WORD_W{1'b0}};
        end else begin
            ready_r <= (next_s == RESP);
            err_r   <= (next_s == RESP) && resp_err_s;
            rdata_r <= (next_s == RESP) ? resp_rdata_s : {WORD_W{1'b0}};
        end
    end

    // Store commits on the edge leaving RESP; never on a reset edge.
    assign ram_we_s = (state_r == RESP) && we_r && !err_r && !reset;

    ram_sp #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (src_addr_s[ADDR_W+1:2]),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Upper address bits alias and are deliberately ignored.
    assign addr_unused_s = ^src_addr_s[WORD_W-1:ADDR_W+2];

    assign bus.busy  = (state_r != IDLE);
    assign bus.ready = ready_r;
    assign bus.err   = err_r;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder: a LATENCY=2 and a
// LATENCY=0 instance checked every cycle against a time-based reference model.
module tb_dmem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        d_req [2];
    logic        d_we  [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];
    logic        o_busy [2];
    logic        o_ready [2];
    logic        o_err [2];
    logic [31:0] o_rdata [2];

    dmem_if bus_a ();
    dmem_if bus_b ();

    assign bus_a.req   = d_req[0];
    assign bus_a.we    = d_we[0];
    assign bus_a.addr  = d_addr[0];
    assign bus_a.wdata = d_wdata[0];
    assign bus_b.req   = d_req[1];
    assign bus_b.we    = d_we[1];
    assign bus_b.addr  = d_addr[1];
    assign bus_b.wdata = d_wdata[1];
    assign o_busy[0]  = bus_a.busy;
    assign o_ready[0] = bus_a.ready;
    assign o_err[0]   = bus_a.err;
    assign o_rdata[0] = bus_a.rdata;
    assign o_busy[1]  = bus_b.busy;
    assign o_ready[1] = bus_b.ready;
    assign o_err[1]   = bus_b.err;
    assign o_rdata[1] = bus_b.rdata;

    dmem_responder #(.ADDR_W(6), .LATENCY(2)) dut  (.clk(clk), .reset(reset), .bus(bus_a));
    dmem_responder #(.ADDR_W(6), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a request accepted at edge a responds after edge a+LAT,
    // and a store lands in the array at edge a+LAT+1.
    int          cyc = 0;
    bit          pend [2];
    int          acc_at [2];
    bit          acc_ev [2];
    bit          m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] mem_m [2][64];
    bit          e_busy [2];
    bit          e_ready [2];
    bit          e_err [2];
    logic [31:0] e_rdata [2];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                acc_ev[k] = 1'b0;
                if (reset) begin
                    pend[k] = 1'b0;
                end else if (pend[k]) begin
                    if (cyc == acc_at[k] + lat_of(k) + 1) begin
                        if (m_we[k] && (m_addr[k] % 4 == 0))
                            mem_m[k][(m_addr[k] / 4) % 64] = m_wdata[k];
                        pend[k] = 1'b0;
                    end
                end else if (d_req[k]) begin
                    pend[k]    = 1'b1;
                    acc_at[k]  = cyc;
                    acc_ev[k]  = 1'b1;
                    m_we[k]    = d_we[k];
                    m_addr[k]  = d_addr[k];
                    m_wdata[k] = d_wdata[k];
                end
                e_busy[k]  = pend[k];
                e_ready[k] = pend[k] && (cyc == acc_at[k] + lat_of(k));
                e_err[k]   = e_ready[k] && (m_addr[k] % 4 != 0);
                e_rdata[k] = (e_ready[k] && !m_we[k] && !e_err[k]) ?
                             mem_m[k][(m_addr[k] / 4) % 64] : 32'h0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy%0d", k), {31'h0, o_busy[k]}, {31'h0, e_busy[k]});
                chk($sformatf("ready%0d", k), {31'h0, o_ready[k]}, {31'h0, e_ready[k]});
                if (e_ready[k]) begin
                    chk($sformatf("rdata%0d", k), o_rdata[k], e_rdata[k]);
                    chk($sformatf("err%0d", k), {31'h0, o_err[k]}, {31'h0, e_err[k]});
                end
            end
        end
    end

    task automatic issue(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rd, output logic er);
        bit got;
        lat = -1;
        rd  = 32'h0;
        er  = 1'b0;
        d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = acc_ev[k];
        end
        chk($sformatf("accept%0d", k), {31'h0, got}, 32'h1);
        d_req[k] = 1'b0; d_we[k] = 1'($urandom); d_addr[k] = $urandom; d_wdata[k] = $urandom;
        if (!got) return;
        got = 1'b0;
        for (int n = 1; n <= 10 && !got; n++) begin
            @(negedge clk);
            if (o_ready[k]) begin
                got = 1'b1; lat = n; rd = o_rdata[k]; er = o_err[k];
            end
        end
        chk($sformatf("ready_seen%0d", k), {31'h0, got}, 32'h1);
    endtask

    task automatic hold_test(input int k, input int exp_space, input int exp_busy, input int ncyc);
        int prev = -1;
        int bc   = 0;
        int nacc = 0;
        d_we[k]  = 1'b0;
        d_req[k] = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (o_busy[k]) bc++;
            d_addr[k] = (i % 2 == 1) ? 32'h0000_0010 : 32'h0000_0104;
            @(posedge clk); #1;
            if (acc_ev[k]) begin
                if (prev >= 0) begin
                    chk($sformatf("hold_space%0d", k), cyc - prev, exp_space);
                    chk($sformatf("hold_busy%0d", k), bc, exp_busy);
                end
                prev = cyc;
                bc   = 0;
                nacc++;
            end
        end
        d_req[k] = 1'b0;
        chk($sformatf("hold_nacc%0d", k), nacc, ncyc / exp_space);
        repeat (exp_space + 1) @(negedge clk);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    bit          got;

    initial begin
        for (int k = 0; k < 2; k++) begin
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_busy%0d", k), {31'h0, o_busy[k]}, 32'h0);
            chk($sformatf("rst_ready%0d", k), {31'h0, o_ready[k]}, 32'h0);
            chk($sformatf("rst_err%0d", k), {31'h0, o_err[k]}, 32'h0);
            chk($sformatf("rst_rdata%0d", k), o_rdata[k], 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Fill both arrays so every later load has a defined expectation.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++)
                issue(k, 1'b1, 32'(i * 4), $urandom, lat, rd, er);

        issue(0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, lat, rd, er);
        chk("st_lat", lat, 3); chk("st_rdata", rd, 32'h0); chk("st_err", {31'h0, er}, 32'h0);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er);
        chk("ld_lat", lat, 3); chk("ld_rdata", rd, 32'hDEADBEEF); chk("ld_err", {31'h0, er}, 32'h0);

        issue(0, 1'b1, 32'h0000_0010, 32'h12345678, lat, rd, er);
        issue(0, 1'b0, 32'h0000_0013, 32'h0, lat, rd, er);
        chk("mis_lat", lat, 3); chk("mis_err", {31'h0, er}, 32'h1); chk("mis_rdata", rd, 32'h0);
        issue(0, 1'b1, 32'h0000_0012, 32'hBAD0BAD0, lat, rd, er);
        chk("mis_st_err", {31'h0, er}, 32'h1);
        issue(0, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er);
        chk("after_mis", rd, 32'h12345678);

        issue(0, 1'b1, 32'h0000_0104, 32'hA5A5A5A5, lat, rd, er);
        issue(0, 1'b0, 32'h0000_0004, 32'h0, lat, rd, er);
        chk("alias", rd, 32'hA5A5A5A5); chk("alias_err", {31'h0, er}, 32'h0);

        issue(1, 1'b1, 32'h0000_0040, 32'hCAFEF00D, lat, rd, er);
        chk("l0_st_lat", lat, 1);
        issue(1, 1'b0, 32'h0000_0040, 32'h0, lat, rd, er);
        chk("l0_ld_lat", lat, 1); chk("l0_ld_rdata", rd, 32'hCAFEF00D);

        hold_test(0, 4, 3, 24);
        hold_test(1, 2, 1, 12);

        // Reset during the WAIT of a second store to the same word.
        issue(0, 1'b1, 32'h0000_0020, 32'h11111111, lat, rd, er);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h0000_0020; d_wdata[0] = 32'h22222222;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = acc_ev[0];
        end
        chk("rst_accept", {31'h0, got}, 32'h1);
        d_req[0] = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", {31'h0, o_busy[0]}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, o_busy[0]}, 32'h0);
        chk("mid_rst_ready", {31'h0, o_ready[0]}, 32'h0);
        chk("mid_rst_err", {31'h0, o_err[0]}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        issue(0, 1'b0, 32'h0000_0020, 32'h0, lat, rd, er);
        chk("rst_no_commit", rd, 32'h11111111);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 150; i++) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                issue(k, 1'($urandom), a, $urandom, lat, rd, er);
                chk($sformatf("rnd_lat%0d", k), lat, lat_of(k) + 1);
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
